pc_fetch: RTL and testbench

- Program counter and fetch sequencer for picoMIPS; sits directly upstream of pmem and drives its address input.
- Each cycle it presents one PC to pmem (combinational read), so the decoder sees the instruction word in the same cycle.
- Next PC is chosen from halt, resume, stall, jump, branch and increment requests returned by the decoder.
- Parameter widths come from picoMIPS_package.

---
 rtl/picoMIPS_package.sv | 6 +
 rtl/pc_fetch.sv | 129 ++++++++++++
 tb/tb_pc_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/picoMIPS_package.sv
// Shared picoMIPS configuration constants.
package picoMIPS_package;

  localparam int PMEM_WIDTH = 8;

endpackage : picoMIPS_package

// File: rtl/pc_fetch.sv
// picoMIPS program counter and fetch sequencer: BOOT/RUN/HALT control driving the pmem address.
// Optional build macro PC_WRAP_TRAP_EN: sequential PC overflow halts the core and sets sticky wrap_err.
module pc_fetch #(
  parameter int                    PMEM_WIDTH = picoMIPS_package::PMEM_WIDTH,
  parameter logic [PMEM_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  resume,
  input  logic                  jump_en,
  input  logic [PMEM_WIDTH-1:0] jump_addr,
  input  logic                  branch_en,
  input  logic [PMEM_WIDTH-1:0] branch_off,
  output logic [PMEM_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  halted,
  output logic                  wrap_err
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [PMEM_WIDTH-1:0]   pc_q, pc_next;
  logic [PMEM_WIDTH-1:0]   pc_inc;
  logic [PMEM_WIDTH-1:0]   pc_branch;
  logic                    advance;

  assign pc_inc    = pc_q + PMEM_WIDTH'(1);
  assign pc_branch = pc_q + branch_off;

`ifdef PC_WRAP_TRAP_EN
  logic wrap_q;
  logic wrap_set;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    advance    = 1'b0;
`ifdef PC_WRAP_TRAP_EN
    wrap_set   = 1'b0;
`endif

    unique case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end

      ST_RUN: begin
        if (halt) begin
          state_next = ST_HALT;
        end else if (stall) begin
          pc_next = pc_q;
        end else if (jump_en) begin
          pc_next = jump_addr;
        end else if (branch_en) begin
          pc_next = pc_branch;
        end else begin
          advance = 1'b1;
        end
      end

      ST_HALT: begin
        // Resume beats a re-decoded HALT at the frozen pc.
        if (resume) begin
          advance = 1'b1;
        end
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase

    // Sequential step shared by RUN increment and HALT resume.
    if (advance) begin
`ifdef PC_WRAP_TRAP_EN
      if (pc_q == '1) begin
        state_next = ST_HALT;
        wrap_set   = 1'b1;
      end else begin
        pc_next    = pc_inc;
        state_next = ST_RUN;
      end
`else
      pc_next    = pc_inc;
      state_next = ST_RUN;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_BOOT;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

`ifdef PC_WRAP_TRAP_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrap_q <= 1'b0;
    end else if (wrap_set) begin
      wrap_q <= 1'b1;
    end
  end

  assign wrap_err = wrap_q;
`else
  assign wrap_err = 1'b0;
`endif

  // Status outputs decode only the state register, so data inputs cannot glitch them.
  assign pc       = pc_q;
  assign pc_valid = (state == ST_RUN);
  assign halted   = (state == ST_HALT);

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch at PMEM_WIDTH=4: directed vector table, multi-cycle sequences, random vs model.
module tb_pc_fetch;

  localparam int W = 4;
  localparam int N = 1 << W;
`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic         clk = 1'b0;
  logic         nReset;
  logic         stall, halt, resume, jump_en, branch_en;
  logic [W-1:0] jump_addr, branch_off;
  logic [W-1:0] pc;
  logic         pc_valid, halted, wrap_err;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch position, mode and sticky overflow flag.
  int m_pc;
  int m_mode;
  bit m_wrap;

  pc_fetch #(.PMEM_WIDTH(W), .RESET_PC('0)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .stall      (stall),
    .halt       (halt),
    .resume     (resume),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .halted     (halted),
    .wrap_err   (wrap_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       stall, halt, resume, jump_en;
    bit [3:0] jump_addr;
    bit       branch_en;
    bit [3:0] branch_off;
    int       exp_pc;
    bit       exp_valid, exp_halted, exp_wrap;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input bit s, input bit h, input bit r, input bit je, input int ja,
                              input bit be, input int bo, input int epc, input bit ev,
                              input bit eh, input bit ew);
    vec_t v;
    v.stall = s; v.halt = h; v.resume = r; v.jump_en = je; v.jump_addr = 4'(ja);
    v.branch_en = be; v.branch_off = 4'(bo);
    v.exp_pc = epc; v.exp_valid = ev; v.exp_halted = eh; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int epc, input bit ev, input bit eh, input bit ew);
    check({tag, "_pc"},       32'(pc),       32'(epc));
    check({tag, "_pc_valid"}, 32'(pc_valid), 32'(ev));
    check({tag, "_halted"},   32'(halted),   32'(eh));
    check({tag, "_wrap_err"}, 32'(wrap_err), 32'(ew));
  endtask

  task automatic set_inputs(input bit s, input bit h, input bit r, input bit je, input int ja,
                            input bit be, input int bo);
    stall = s; halt = h; resume = r; jump_en = je; jump_addr = W'(ja);
    branch_en = be; branch_off = W'(bo);
  endtask

  task automatic model_advance();
    if (TRAP && m_pc == N - 1) begin
      m_mode = M_HALT;
      m_wrap = 1'b1;
    end else begin
      m_pc   = (m_pc + 1) % N;
      m_mode = M_RUN;
    end
  endtask

  task automatic model_step(input bit s, input bit h, input bit r, input bit je, input int ja,
                            input bit be, input int bo);
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (h)       m_mode = M_HALT;
      else if (s)  m_pc = m_pc;
      else if (je) m_pc = ja;
      else if (be) m_pc = (m_pc + bo) % N;
      else         model_advance();
    end else if (r) begin
      model_advance();
    end
  endtask

  // Hold reset across two edges, check reset values, release just after an edge, check BOOT.
  task automatic do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    nReset = 1'b1;
    #1;
    check_outs("boot", 0, 0, 0, 0);
    m_pc = 0; m_mode = M_BOOT; m_wrap = 1'b0;
  endtask

  initial begin
    nReset = 1'b1;
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    #2;
    nReset = 1'b0;
    #1;
    check_outs("por", 0, 0, 0, 0);

    //            s  h  r  je ja  be bo   pc  v  h  w
    vecs[0]  = mk(1, 1, 0, 1, 9,  1, 3,   0,  1, 0, 0);   // BOOT ignores requests
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 0,   1,  1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,  0, 0,   2,  1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0,   3,  1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 12, 1, 1,   12, 1, 0, 0);   // jump beats branch
    vecs[5]  = mk(0, 0, 0, 1, 5,  0, 0,   5,  1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0,  1, 13,  2,  1, 0, 0);   // 5 + (-3)
    vecs[7]  = mk(0, 0, 0, 0, 0,  1, 7,   9,  1, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0,  0, 0,   9,  0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 1, 3,  1, 2,   9,  0, 1, 0);   // HALT ignores stall/jump/branch
    vecs[10] = mk(0, 1, 1, 0, 0,  0, 0,   10, 1, 0, 0);   // resume beats halt
    vecs[11] = mk(0, 0, 0, 1, 7,  0, 0,   7,  1, 0, 0);
    vecs[12] = mk(1, 0, 0, 1, 14, 0, 0,   7,  1, 0, 0);
    vecs[13] = mk(1, 0, 0, 1, 14, 0, 0,   7,  1, 0, 0);
    vecs[14] = mk(1, 0, 0, 1, 14, 0, 0,   7,  1, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 14, 0, 0,   14, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0,  0, 0,   15, 1, 0, 0);
    vecs[17] = TRAP ? mk(0, 0, 0, 0, 0, 0, 0, 15, 0, 1, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[18] = TRAP ? mk(0, 0, 0, 0, 0, 0, 0, 15, 0, 1, 1) : mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[19] = TRAP ? mk(0, 0, 1, 0, 0, 0, 0, 15, 0, 1, 1) : mk(0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_inputs(vecs[i].stall, vecs[i].halt, vecs[i].resume, vecs[i].jump_en,
                 int'(vecs[i].jump_addr), vecs[i].branch_en, int'(vecs[i].branch_off));
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                 vecs[i].exp_halted, vecs[i].exp_wrap);
    end

    // Asynchronous reset from wherever the table left the core (HALT with wrap_err under the trap build).
    #2;
    nReset = 1'b0;
    #1;
    check_outs("async_reset_end", 0, 0, 0, 0);

    // Free-run with no requests through the top address.
    do_reset();
    for (int i = 0; i < N; i++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("free%0d", i), i, 1, 0, 0);
    end
    @(posedge clk);
    #1;
    check_outs("free_top", TRAP ? N - 1 : 0, !TRAP, TRAP, TRAP);
    @(posedge clk);
    #1;
    check_outs("free_after", TRAP ? N - 1 : 1, !TRAP, TRAP, TRAP);

    // Reset mid-cycle while running at pc=6, then BOOT and run again from 0.
    do_reset();
    repeat (7) @(posedge clk);
    #1;
    check_outs("pre_reset", 6, 1, 0, 0);
    #2;
    nReset = 1'b0;
    #1;
    check_outs("mid_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    #1;
    check_outs("reboot", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rerun0", 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rerun1", 1, 1, 0, 0);

    // Random requests against the reference model, re-reset periodically.
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        bit s, h, r, je, be;
        int ja, bo;
        h  = ($urandom_range(15) == 0);
        s  = ($urandom_range(3) == 0);
        r  = ($urandom_range(2) == 0);
        je = ($urandom_range(7) == 0);
        be = ($urandom_range(3) == 0);
        ja = int'($urandom_range(N - 1));
        bo = int'($urandom_range(N - 1));
        set_inputs(s, h, r, je, ja, be, bo);
        model_step(s, h, r, je, ja, be, bo);
        @(posedge clk);
        #1;
        check_outs($sformatf("rnd%0d_%0d", blk, c), m_pc, m_mode == M_RUN, m_mode == M_HALT, m_wrap);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_fetch
